// File: rtl/unary_pkg.sv
// Shared types and defaults for the unary MAC result path.
package unary_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } collector_state_t;

    localparam int DEFAULT_BIN_BITS = 4;

    // Result width able to hold a full-scale a*b+c from the upstream MAC.
    function automatic int unary_out_bits(input int bin_bits);
        return 2 * bin_bits + 1;
    endfunction

endpackage

// File: rtl/unary_quiet_timer.sv
// Counts consecutive quiet cycles on the unary stream; flags the cycle that
// completes IDLE_CYCLES of silence.
module unary_quiet_timer #(
    parameter int IDLE_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pulse,
    output logic expired
);

    localparam int QW = $clog2(IDLE_CYCLES);
    localparam logic [QW-1:0] LAST = QW'(IDLE_CYCLES - 1);

    logic [QW-1:0] quiet_q;
    logic [QW-1:0] quiet_d;

    always_comb begin
        if (clear || pulse) begin
            quiet_d = '0;
        end else begin
            quiet_d = quiet_q + QW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quiet_q <= '0;
        end else begin
            quiet_q <= quiet_d;
        end
    end

    assign expired = !pulse && (quiet_q == LAST);

endmodule

// File: rtl/unary_stream_collector.sv
// Counts pulses on a unary stream and hands the total out as a binary word
// on a valid/ready handshake once the stream has gone quiet.
module unary_stream_collector
    import unary_pkg::*;
#(
    parameter int BIN_BITS    = DEFAULT_BIN_BITS,
    parameter int OUT_BITS    = unary_out_bits(BIN_BITS),
    parameter int IDLE_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                unary_in,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [OUT_BITS-1:0] result,
    output logic                overflow,
    output logic                late
);

    localparam logic [OUT_BITS-1:0] CNT_MAX = '1;

    collector_state_t    state_q;
    logic [OUT_BITS-1:0] count_q;
    logic [OUT_BITS-1:0] result_q;
    logic                valid_q;
    logic                busy_q;
    logic                overflow_q;
    logic                late_q;

    logic handshake;
    logic arm;
    logic expired;

    assign handshake = (state_q == HOLD) && valid_q && result_ready;
    // A new collection starts from IDLE or straight out of an accepted HOLD.
    assign arm = start && ((state_q == IDLE) || handshake);

    unary_quiet_timer #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_quiet (
        .clk    (clk),
        .reset  (reset),
        .clear  (arm),
        .pulse  (unary_in),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= COUNT;
                        busy_q     <= 1'b1;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        late_q     <= 1'b0;
                    end
                end
                COUNT: begin
                    if (unary_in) begin
                        if (count_q == CNT_MAX) begin
                            overflow_q <= 1'b1;
                        end else begin
                            count_q <= count_q + OUT_BITS'(1);
                        end
                    end else if (expired) begin
                        result_q <= count_q;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (unary_in) begin
                        late_q <= 1'b1;
                    end
                    // Back-to-back start overrides a late pulse seen this cycle.
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            state_q    <= COUNT;
                            count_q    <= '0;
                            overflow_q <= 1'b0;
                            late_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign late         = late_q;

endmodule

// File: doc/unary_stream_collector.md
# unary_stream_collector

Downstream stage of `unary_shift_mac`. Counts the 1-cycles on the MAC's unary `out` stream and declares the result complete after a programmable quiet period. Presents the count as a binary word on a valid/ready handshake. Replaces ad-hoc bench counters and lets MAC results feed binary logic.

## Interface
- `BIN_BITS`, default 4: operand width of the upstream MAC.
- `OUT_BITS`, default `2*BIN_BITS+1` (9): result width; holds 15*15+15 = 240.
- `IDLE_CYCLES`, default 32: consecutive quiet cycles that end a result. Must be ≥ 2 and exceed the MAC's worst-case gap between output pulses.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  arms one collection; accepted only as defined under Operation.
- `unary_in`  in  1  unary stream from the MAC `out`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `result_valid`  out  1  result bundle is valid.
- `result_ready`  in  1  consumer accepts the bundle.
- `result`  out  OUT_BITS  pulse count.
- `overflow`  out  1  a pulse arrived while the count was saturated.
- `late`  out  1  a pulse arrived while in HOLD.

## Operation
- States: IDLE, COUNT, HOLD.
- Reset values: state IDLE, all counters 0, `busy` 0, `result_valid` 0, `result` 0, `overflow` 0, `late` 0. Reset wins over every other event, including mid-COUNT and mid-HOLD.
- **IDLE**
  - `unary_in` is ignored.
  - `start`=1 → COUNT; pulse count, quiet counter, `overflow` and `late` all cleared.
  - `result` keeps its last value.
- **COUNT**
  - `unary_in`=1: count += 1, saturating at 2^OUT_BITS−1. A pulse while already saturated sets sticky `overflow`. Quiet counter → 0.
  - `unary_in`=0: quiet counter += 1.
  - When a 0 is sampled with the quiet counter at IDLE_CYCLES−1 (that cycle is the IDLE_CYCLES-th consecutive quiet cycle): `result` ← count, `result_valid` ← 1, → HOLD.
  - `start` is ignored.
- **HOLD**
  - `result`, `overflow` and `result_valid` stay stable until the handshake.
  - `unary_in`=1 sets sticky `late`; the count is unchanged.
  - Handshake: `result_valid` & `result_ready` → `result_valid` ← 0.
    - Without `start` in the same cycle: → IDLE.
    - With `start` in the same cycle: → COUNT directly, with the same clears as IDLE→COUNT (back-to-back operation).
  - `start` without the handshake is ignored.
- Width rules:
  - Quiet counter width: `$clog2(IDLE_CYCLES)`.
  - Pulse count is OUT_BITS wide; it never wraps.

## Timing
- Let S be the cycle in which `start` is sampled. Counting samples `unary_in` from S+1 onward; a pulse in cycle S is not counted.
- `busy` is high from S+1.
- Last pulse in cycle P → `result_valid` is high from cycle P+IDLE_CYCLES+1.
- No pulses at all → `result_valid` is high from S+IDLE_CYCLES+1 with `result`=0.
- Gaps shorter than IDLE_CYCLES do not end the result.
- Handshake in cycle H → `result_valid` is low from H+1; `busy` is low from H+1 unless `start` was also high in H.
- `result_ready` may be held high permanently. `result_valid` then lasts exactly one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `unary_pkg`:
  - `collector_state_t` enum {IDLE, COUNT, HOLD}.
  - `BIN_BITS` default constant.
  - Localparam function for the default `OUT_BITS`.
- One sub-module, `unary_quiet_timer`:
  - Inputs: `clk`, `reset`, `clear`, `pulse`.
  - Output: `expired`, asserted combinationally when `pulse`=0 and the count equals IDLE_CYCLES−1.
  - Parameterised by IDLE_CYCLES.
- Top-level holds the FSM, the saturating counter and the output registers.

## Test plan
- Reset: hold `reset` 2 cycles during random `unary_in`/`start` → all outputs 0, state IDLE, `busy` 0.
- Basic: `start`, then 12 contiguous pulses (3*2+6) with `result_ready`=1 → `result`=12, valid exactly at P+33 for one cycle, `overflow`=0, `late`=0. A pulse also driven in cycle S is not counted.
- Gapped and zero:
  - 225 pulses separated by 31-cycle gaps → `result`=225, a single valid.
  - `start` with no pulses → `result`=0 at S+33.
  - 10 pulses, a 32-cycle gap, then 5 pulses → `result`=10, `late`=1.
- Saturation: 600 pulses → `result`=511, `overflow`=1. The next `start` clears `overflow`.
- Backpressure/back-to-back:
  - Hold `result_ready`=0 for 10 cycles in HOLD while pulsing `unary_in` → `result` stable, `late`=1.
  - Then `result_ready`=1 with `start`=1 in the same cycle → COUNT directly, `late` cleared, next result (4*15+3 = 63 pulses) is correct.
- Reset mid-operation: assert `reset` after 7 pulses in COUNT → IDLE, no `result_valid`. A new `start` with 11 pulses → `result`=11.
